// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch_unit (master) and memory (slave).
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with redirect/drop handling.
// Optional macro FETCH_MISALIGN_EN: misaligned redirect targets raise fetch_fault.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               redirect_valid,
  input  logic [63:0]        redirect_pc,
  input  logic               stall,
  fetch_unit_if.master       imem,
  output logic               inst_valid,
  output logic [31:0]        inst_data,
  output logic [63:0]        inst_pc,
  output logic               flush,
  output logic               fetch_fault
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;

  state_t      state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic        drop, drop_nxt;
  logic        inst_valid_nxt;
  logic        capture;
  logic        handshake;
  logic        misalign;
  logic [63:0] target;

`ifdef FETCH_MISALIGN_EN
  assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign target   = redirect_pc;
`else
  assign misalign = 1'b0;
  assign target   = redirect_pc & ~64'h3;
`endif

  assign imem.imem_req_valid = (state == S_REQ);
  assign imem.imem_addr      = pc;
  assign handshake           = imem.imem_req_valid && imem.imem_req_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_REQ;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    drop_nxt       = drop;
    inst_valid_nxt = inst_valid;
    capture        = 1'b0;

    case (state)
      S_REQ: begin
        if (handshake) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_resp_valid) begin
          drop_nxt = 1'b0;
          if (drop) begin
            state_nxt = S_REQ;
          end else begin
            capture        = 1'b1;
            inst_valid_nxt = 1'b1;
            pc_nxt         = pc + 64'd4;
            state_nxt      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          inst_valid_nxt = 1'b0;
          state_nxt      = S_REQ;
        end
      end
      S_FAULT: begin
        // a request issued just before the fault still retires here
        if (imem.imem_resp_valid) drop_nxt = 1'b0;
      end
      default: state_nxt = S_REQ;
    endcase

    // redirect overrides stall and normal sequencing in every state
    if (redirect_valid) begin
      pc_nxt         = target;
      capture        = 1'b0;
      inst_valid_nxt = 1'b0;
      case (state)
        S_REQ: begin
          if (handshake) drop_nxt = 1'b1;
        end
        S_WAIT: begin
          if (imem.imem_resp_valid) begin
            drop_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            drop_nxt  = 1'b1;
            state_nxt = S_WAIT;
          end
        end
        S_HOLD:  state_nxt = S_REQ;
        S_FAULT: state_nxt = drop_nxt ? S_WAIT : S_REQ;
        default: state_nxt = S_REQ;
      endcase
      if (misalign) state_nxt = S_FAULT;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc         <= RESET_PC;
      drop       <= 1'b0;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
      flush      <= 1'b0;
    end else begin
      pc         <= pc_nxt;
      drop       <= drop_nxt;
      inst_valid <= inst_valid_nxt;
      flush      <= redirect_valid;
      if (capture) begin
        inst_data <= imem.imem_resp_data;
        inst_pc   <= pc;
      end
    end
  end

`ifdef FETCH_MISALIGN_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) fetch_fault <= 1'b0;
    else       fetch_fault <= (state_nxt == S_FAULT);
  end
`else
  assign fetch_fault = 1'b0;
`endif

endmodule
